// File: rtl/motor_pwm_sequencer.sv
// Two-channel H-bridge PWM sequencer. Signed 8-bit drive commands are latched through a
// valid/ready shadow register, applied on PWM period boundaries, with dead time on reversal.
module motor_pwm_sequencer #(
    parameter int PRESCALE = 23,
    parameter int DEADTIME = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] motor1_count,
    input  logic       motor1_sign,
    input  logic [7:0] motor2_count,
    input  logic       motor2_sign,
    output logic       enable12,
    output logic       enable34,
    output logic       a1,
    output logic       a2,
    output logic       a3,
    output logic       a4,
    output logic       period_start
);
    localparam int PW = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DEAD = 1'b1
    } ch_state_t;

    logic [PW-1:0]   presc_q, presc_d;
    logic [7:0]      pwm_cnt_q, pwm_cnt_d;
    logic            period_start_q, period_start_d;
    logic            pending_q, pending_d;
    logic [1:0][7:0] sh_duty_q, sh_duty_d;
    logic [1:0]      sh_sign_q, sh_sign_d;
    logic            tick, period_end, accept, transfer;
    logic [1:0]      en_w, pos_w, neg_w;

    assign tick       = (presc_q == PW'(PRESCALE));
    assign period_end = tick && (pwm_cnt_q == 8'd254);
    assign cmd_ready  = ~pending_q;
    assign accept     = cmd_valid && ~pending_q;
    // A command accepted on the boundary cycle is not yet pending, so it waits a full period.
    assign transfer   = period_end && pending_q;

    always_comb begin
        presc_d        = tick ? '0 : presc_q + PW'(1);
        pwm_cnt_d      = pwm_cnt_q;
        period_start_d = period_end;
        pending_d      = pending_q;
        sh_duty_d      = sh_duty_q;
        sh_sign_d      = sh_sign_q;
        if (tick) begin
            pwm_cnt_d = (pwm_cnt_q == 8'd254) ? 8'd0 : pwm_cnt_q + 8'd1;
        end
        if (transfer) begin
            pending_d = 1'b0;
        end
        if (accept) begin
            pending_d = 1'b1;
            sh_duty_d = {motor2_count, motor1_count};
            sh_sign_d = {motor2_sign, motor1_sign};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q        <= '0;
            pwm_cnt_q      <= 8'd0;
            period_start_q <= 1'b0;
            pending_q      <= 1'b0;
            sh_duty_q      <= '0;
            sh_sign_q      <= '0;
        end else begin
            presc_q        <= presc_d;
            pwm_cnt_q      <= pwm_cnt_d;
            period_start_q <= period_start_d;
            pending_q      <= pending_d;
            sh_duty_q      <= sh_duty_d;
            sh_sign_q      <= sh_sign_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ch
            ch_state_t  state_q, state_d;
            logic [7:0] duty_q, duty_d, tgt_duty_q, tgt_duty_d;
            logic       sign_q, sign_d, tgt_sign_q, tgt_sign_d;
            logic       driven_q, driven_d;
            logic [3:0] dead_q, dead_d;
            logic       en_q, en_d, pos_q, pos_d, neg_q, neg_d;
            logic [7:0] new_duty;
            logic       new_sign;

            assign new_duty = sh_duty_q[gi];
            assign new_sign = sh_sign_q[gi];

            always_comb begin
                state_d    = state_q;
                duty_d     = duty_q;
                sign_d     = sign_q;
                tgt_duty_d = tgt_duty_q;
                tgt_sign_d = tgt_sign_q;
                driven_d   = driven_q;
                dead_d     = dead_q;
                if (transfer) begin
                    tgt_duty_d = new_duty;
                    tgt_sign_d = new_sign;
                    if (state_q == ST_RUN) begin
                        if (new_sign == sign_q || duty_q == 8'd0 || new_duty == 8'd0) begin
                            duty_d   = new_duty;
                            sign_d   = new_sign;
                            driven_d = 1'b1;
                        end else begin
                            state_d = ST_DEAD;
                            dead_d  = 4'(DEADTIME);
                        end
                    end else if (new_sign == sign_q || dead_q == 4'd1) begin
                        // Either a reversal was cancelled or the running timer just expired.
                        state_d  = ST_RUN;
                        duty_d   = new_duty;
                        sign_d   = new_sign;
                        driven_d = 1'b1;
                    end else begin
                        dead_d = dead_q - 4'd1;
                    end
                end else if (period_end && state_q == ST_DEAD) begin
                    if (dead_q == 4'd1) begin
                        state_d = ST_RUN;
                        duty_d  = tgt_duty_q;
                        sign_d  = tgt_sign_q;
                    end else begin
                        dead_d = dead_q - 4'd1;
                    end
                end
                en_d  = driven_q && (state_q == ST_RUN) && (pwm_cnt_q < duty_q);
                pos_d = driven_q & ~sign_q;
                neg_d = driven_q & sign_q;
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    state_q    <= ST_RUN;
                    duty_q     <= 8'd0;
                    sign_q     <= 1'b0;
                    tgt_duty_q <= 8'd0;
                    tgt_sign_q <= 1'b0;
                    driven_q   <= 1'b0;
                    dead_q     <= 4'd0;
                    en_q       <= 1'b0;
                    pos_q      <= 1'b0;
                    neg_q      <= 1'b0;
                end else begin
                    state_q    <= state_d;
                    duty_q     <= duty_d;
                    sign_q     <= sign_d;
                    tgt_duty_q <= tgt_duty_d;
                    tgt_sign_q <= tgt_sign_d;
                    driven_q   <= driven_d;
                    dead_q     <= dead_d;
                    en_q       <= en_d;
                    pos_q      <= pos_d;
                    neg_q      <= neg_d;
                end
            end

            assign en_w[gi]  = en_q;
            assign pos_w[gi] = pos_q;
            assign neg_w[gi] = neg_q;
        end
    endgenerate

    assign enable12     = en_w[0];
    assign enable34     = en_w[1];
    assign a1           = pos_w[0];
    assign a2           = neg_w[0];
    assign a3           = pos_w[1];
    assign a4           = neg_w[1];
    assign period_start = period_start_q;

endmodule

// File: tb/tb_motor_pwm_sequencer.sv
// Bench for motor_pwm_sequencer with one clk per PWM tick: table of direct-apply commands,
// then hand sequences for dead time, abort, back-to-back handshakes and mid-period reset.
module tb_motor_pwm_sequencer;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] motor1_count = 8'd0;
    logic       motor1_sign = 1'b0;
    logic [7:0] motor2_count = 8'd0;
    logic       motor2_sign = 1'b0;
    logic       enable12, enable34, a1, a2, a3, a4, period_start;

    motor_pwm_sequencer #(.PRESCALE(0), .DEADTIME(2)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .motor1_count(motor1_count), .motor1_sign(motor1_sign),
        .motor2_count(motor2_count), .motor2_sign(motor2_sign),
        .enable12(enable12), .enable34(enable34),
        .a1(a1), .a2(a2), .a3(a3), .a4(a4), .period_start(period_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] m1c;
        logic       m1s;
        logic [7:0] m2c;
        logic       m2s;
        int         e12;
        int         e34;
        logic [3:0] pins;
        int         nper;
    } vec_t;

    typedef struct {
        int         e12;
        int         e34;
        logic [3:0] pins;
    } exp_t;

    vec_t vecs[4];
    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        total++;
        bad++;
        $display("FAIL %s: timed out waiting for the DUT", nm);
    endtask

    task automatic push_exp(input int e12, input int e34, input logic [3:0] pins);
        exp_t e;
        e.e12 = e12;
        e.e34 = e34;
        e.pins = pins;
        exp_q.push_back(e);
    endtask

    task automatic send_cmd(input logic [7:0] c1, input logic s1, input logic [7:0] c2,
                            input logic s2);
        int n = 0;
        while (!cmd_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            timeout("send_wait");
            return;
        end
        motor1_count = c1;
        motor1_sign  = s1;
        motor2_count = c2;
        motor2_sign  = s2;
        cmd_valid    = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        $display("cmd m1=%0d/%0d m2=%0d/%0d accepted", c1, s1, c2, s2);
        chk("ready_drop", int'(cmd_ready), 0);
    endtask

    // Returns on the negedge where the pending command has just been applied.
    task automatic wait_boundary(input string nm);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_ready && n < 1000);
        if (!cmd_ready) timeout(nm);
        else chk({nm, ".pstart_with_ready"}, int'(period_start), 1);
    endtask

    // Samples the 255 output cycles belonging to the period that started on the current negedge.
    task automatic check_next(input string tag);
        exp_t       e;
        int         c12 = 0;
        int         c34 = 0;
        int         ps = 0;
        int         steady = 1;
        logic [3:0] pins = 4'd0;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: scoreboard empty", tag);
            return;
        end
        e = exp_q.pop_front();
        for (int i = 0; i < 255; i++) begin
            @(negedge clk);
            if (i == 0) pins = {a1, a2, a3, a4};
            else if ({a1, a2, a3, a4} !== pins) steady = 0;
            c12 += int'(enable12);
            c34 += int'(enable34);
            ps  += int'(period_start);
        end
        $display("period %s: en12=%0d en34=%0d pins=%b", tag, c12, c34, pins);
        chk({tag, ".en12"}, c12, e.e12);
        chk({tag, ".en34"}, c34, e.e34);
        chk({tag, ".pins"}, int'(pins), int'(e.pins));
        chk({tag, ".pins_steady"}, steady, 1);
        chk({tag, ".pstart_count"}, ps, 1);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int off;
        int n;

        vecs[0] = '{8'd128, 1'b0, 8'd0,   1'b1, 128, 0,   4'b1001, 1};
        vecs[1] = '{8'd255, 1'b0, 8'd0,   1'b1, 255, 0,   4'b1001, 3};
        vecs[2] = '{8'd0,   1'b0, 8'd0,   1'b1, 0,   0,   4'b1001, 1};
        vecs[3] = '{8'd100, 1'b0, 8'd200, 1'b1, 100, 200, 4'b1001, 1};

        repeat (3) @(negedge clk);
        chk("rst.en12", int'(enable12), 0);
        chk("rst.en34", int'(enable34), 0);
        chk("rst.pins", int'({a1, a2, a3, a4}), 0);
        chk("rst.cmd_ready", int'(cmd_ready), 1);
        chk("rst.period_start", int'(period_start), 0);
        reset = 1'b0;

        for (int v = 0; v < 4; v++) begin
            send_cmd(vecs[v].m1c, vecs[v].m1s, vecs[v].m2c, vecs[v].m2s);
            for (int p = 0; p < vecs[v].nper; p++) push_exp(vecs[v].e12, vecs[v].e34, vecs[v].pins);
            wait_boundary($sformatf("v%0d", v));
            for (int p = 0; p < vecs[v].nper; p++) check_next($sformatf("v%0d.p%0d", v, p));
        end

        // Reversal on motor 1, then cancelled by a same-sign command during dead time.
        send_cmd(8'd100, 1'b1, 8'd200, 1'b1);
        wait_boundary("abort.rev");
        send_cmd(8'd60, 1'b0, 8'd200, 1'b1);
        push_exp(60, 200, 4'b1001);
        wait_boundary("abort.back");
        check_next("abort.p0");

        // Full reversal: two blanked periods with old direction held, then new direction.
        send_cmd(8'd100, 1'b1, 8'd200, 1'b1);
        push_exp(0, 200, 4'b1001);
        push_exp(0, 200, 4'b1001);
        push_exp(100, 200, 4'b0101);
        wait_boundary("dead");
        check_next("dead.p0");
        check_next("dead.p1");
        check_next("dead.p2");

        // cmd_valid held high: one accept per period, each right after a boundary.
        motor1_count = 8'd100;
        motor1_sign  = 1'b1;
        motor2_count = 8'd200;
        motor2_sign  = 1'b1;
        cmd_valid    = 1'b1;
        @(negedge clk);
        acc = 0;
        off = 0;
        for (int i = 0; i < 765; i++) begin
            if (cmd_valid && cmd_ready) begin
                acc++;
                if (!period_start) off++;
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        $display("continuous valid: accepts=%0d off_boundary=%0d", acc, off);
        chk("cont.accepts", acc, 3);
        chk("cont.off_boundary", off, 0);
        wait_boundary("cont.drain");

        // Accept exactly on the period_end cycle: applied one boundary later.
        repeat (254) @(negedge clk);
        motor1_count = 8'd30;
        motor1_sign  = 1'b1;
        motor2_count = 8'd90;
        motor2_sign  = 1'b1;
        cmd_valid    = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        $display("cmd m1=30/1 m2=90/1 offered on period_end");
        chk("pe.pstart", int'(period_start), 1);
        chk("pe.still_pending", int'(cmd_ready), 0);
        push_exp(100, 200, 4'b0101);
        push_exp(30, 90, 4'b0101);
        check_next("pe.old");
        chk("pe.ready_after", int'(cmd_ready), 1);
        check_next("pe.new");

        // Reset mid-period with a command pending.
        send_cmd(8'd50, 1'b0, 8'd90, 1'b1);
        repeat (100) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        $display("reset asserted mid-period");
        chk("mid_rst.en12", int'(enable12), 0);
        chk("mid_rst.en34", int'(enable34), 0);
        chk("mid_rst.pins", int'({a1, a2, a3, a4}), 0);
        chk("mid_rst.period_start", int'(period_start), 0);
        chk("mid_rst.cmd_ready", int'(cmd_ready), 1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!period_start && n < 1000);
        if (!period_start) timeout("post_rst.wait");
        chk("post_rst.cmd_ready", int'(cmd_ready), 1);
        push_exp(0, 0, 4'b0000);
        check_next("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/motor_pwm_sequencer.md
Name: motor_pwm_sequencer

Overview:
- Turns the two motor drive commands (8-bit magnitude plus sign per motor) into H-bridge control signals: enable PWM and direction pins.
- Commands enter through a valid/ready handshake and are applied only on PWM period boundaries.
- A per-channel dead-time state machine blanks the bridge before any direction reversal, so the bridge never reverses while driven.
- Sits between the balance-control command source and the motor driver pins; clocked from the internal 6 MHz oscillator.

Parameters:
- PRESCALE, 23, clk cycles per PWM tick minus 1. 6 MHz / 24 = 250 kHz ticks.
- DEADTIME, 2, full PWM periods of forced-off enable on a direction reversal. Range 1..15.

Ports:
- clk  in  1  system clock (6 MHz HSOSC).
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  shadow register free; command accepted when cmd_valid && cmd_ready.
- motor1_count  in  8  motor 1 duty magnitude, 0..255.
- motor1_sign  in  1  motor 1 direction, 0 = forward.
- motor2_count  in  8  motor 2 duty magnitude.
- motor2_sign  in  1  motor 2 direction.
- enable12  out  1  motor 1 bridge enable (PWM).
- enable34  out  1  motor 2 bridge enable (PWM).
- a1, a2  out  1 each  motor 1 direction pins.
- a3, a4  out  1 each  motor 2 direction pins.
- period_start  out  1  one-cycle pulse on the first cycle of each PWM period.

Behaviour:
- Reset (async):
  - All outputs 0 except cmd_ready = 1.
  - Prescaler and pwm_cnt = 0.
  - Shadow cleared; pending = 0.
  - Per channel: duty = 0, sign = 0, driven = 0, state RUN.
  - Asserting reset mid-operation drops any pending command.
- Prescaler:
  - Counts 0..PRESCALE. tick = (prescaler == PRESCALE).
  - pwm_cnt (8 bit) advances on tick and wraps 254 → 0, so a period is 255 ticks.
  - period_end = tick && pwm_cnt == 254.
  - period_start is registered: high the cycle after period_end.
- Handshake:
  - cmd_ready = ~pending (combinational).
  - On accept, all four command fields are captured into the shadow and pending is set.
  - At period_end with pending = 1: shadow is transferred to each channel's target, and pending clears on the next cycle.
  - A command accepted in the same cycle as period_end is not applied at that boundary; it is applied at the next one.
- Per-channel FSM, evaluated only at period_end when a transfer occurs:
  - RUN, apply directly: if the new sign equals the active sign, or active duty == 0, or new duty == 0, load duty and sign immediately, set driven = 1, stay in RUN.
  - RUN → DEAD: otherwise, load dead_cnt = DEADTIME and keep the old sign. Target duty and sign are held.
  - DEAD, timer: each period_end decrements dead_cnt. When it reaches 0, load target duty and sign and return to RUN.
  - DEAD, new transfer: the target is replaced. If the new sign equals the active sign, abort to RUN and load immediately. If not, the timer continues without restarting.
- Outputs, registered, one clk after the compare:
  - enableX = driven && state == RUN && (pwm_cnt < duty).
  - duty 255 gives enable constantly high; duty 0 gives enable constantly low.
  - a1 = driven & ~sign1; a2 = driven & sign1; a3 and a4 likewise from sign2.
  - Before the first applied command, all direction pins are 0 (coast).
  - In DEAD, enable = 0 and the direction pins keep the old sign.
- Channels are independent. One channel can be in DEAD while the other applies its command immediately.

Test Plan:
- Reset → enable12 = enable34 = 0, a1..a4 = 0, cmd_ready = 1, period_start = 0. Assert reset mid-period with pending = 1 → all outputs 0 immediately and pending cleared.
- PRESCALE = 0; command m1 = 128/sign 0, m2 = 0/sign 1 →
  - cmd_ready drops on accept and returns high the cycle after the next period_end.
  - Then enable12 is high for exactly 128 of 255 cycles per period; a1 = 1, a2 = 0.
  - enable34 stays 0; a3 = 0, a4 = 1.
- Command m1 = 255 → enable12 continuously high across 3 periods. Then m1 = 0 → enable12 low from the following period, direction pins unchanged.
- DEADTIME = 2, m1 = 100/sign 0 running, then m1 = 100/sign 1 →
  - enable12 = 0 for exactly 2 full periods, with a1 = 1 and a2 = 0 held.
  - Then a1 = 0, a2 = 1, and 100/255 PWM resumes.
  - Motor 2 PWM is unaffected throughout.
- During DEAD, send m1 = 60/sign 0 → at the next period_end channel 1 returns to RUN with 60/255 duty, a1 = 1. No waiting for the remaining dead time.
- Hold cmd_valid high continuously → exactly one command is accepted per period. A command accepted on the period_end cycle is applied only at the following boundary.
